// File: rtl/store_align_unit.sv
// store_align_unit: narrows/aligns byte, half and word stores into memory lanes under a req/ack handshake.
module store_align_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic legal, accept, load, timeout;
    logic [31:0] wdata_n;
    logic [3:0] be_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            misalign <= accept & ~legal;
            bus_err  <= timeout;
            if (load) begin
                mem_addr  <= {st_addr[31:2], 2'b00};
                mem_wdata <= wdata_n;
                mem_be    <= be_n;
            end
        end
    end
    // A completing ack frees the unit in the same cycle, allowing one store per cycle.
    always_comb begin
        st_ready = ~rst & ((state == IDLE) | mem_ack);
        stall    = st_valid & ~st_ready;
        mem_req  = (state == BUSY);
        legal    = (st_size == 2'b00) | ((st_size == 2'b01) & ~st_addr[0]) |
                   ((st_size == 2'b10) & (st_addr[1:0] == 2'b00));
        accept   = st_valid & st_ready;
        load     = accept & legal;
        timeout  = (state == BUSY) & ~mem_ack & (cnt == TO);
        wdata_n  = (st_size == 2'b00) ? {4{st_data[7:0]}} :
                   (st_size == 2'b01) ? {2{st_data[15:0]}} : st_data;
        be_n     = (st_size == 2'b00) ? (4'b0001 << st_addr[1:0]) :
                   (st_size == 2'b01) ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        state_n  = load ? BUSY : ((state == BUSY) & (mem_ack | timeout)) ? IDLE : state;
        cnt_n    = load ? 8'd1 : (state_n == BUSY) ? cnt + 8'd1 : 8'd0;
    end
endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: directed-vector bench for store_align_unit with hand-computed expectations.
module tb_store_align_unit;
    logic        clk = 1'b0;
    logic        rst, st_valid, st_ready, mem_req, mem_ack, stall, misalign, bus_err;
    logic [31:0] st_addr, st_data, mem_addr, mem_wdata;
    logic [1:0]  st_size;
    logic [3:0]  mem_be;
    int errs = 0;
    int checks = 0;
    int req_n, stall_n, err_n, err_at;

    store_align_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .stall(stall),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_ready_low", st_ready, 0);
        chk("rst_req", mem_req, 0);
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("post_rst_ready", st_ready, 1);
        chk("post_rst_addr", mem_addr, 0);
        chk("post_rst_wdata", mem_wdata, 0);
        chk("post_rst_be", mem_be, 0);
        chk("post_rst_flags", {misalign, bus_err, mem_req}, 0);

        // byte store, ack on third BUSY cycle, next word request waiting behind it
        cyc();
        req(32'h1003, 32'h0000_00AB, 2'b00);
        @(negedge clk);
        chk("t1_ready", st_ready, 1);
        chk("t1_stall0", stall, 0);
        cyc();
        req(32'h3000, 32'h1122_3344, 2'b10);
        req_n = 0; stall_n = 0;
        @(negedge clk);
        chk("t1_addr", mem_addr, 32'h1000);
        chk("t1_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("t1_be", mem_be, 4'b1000);
        req_n += int'(mem_req); stall_n += int'(stall);
        cyc();
        @(negedge clk);
        req_n += int'(mem_req); stall_n += int'(stall);
        cyc();
        mem_ack = 1'b1;
        @(negedge clk);
        req_n += int'(mem_req); stall_n += int'(stall);
        chk("t1_ack_ready", st_ready, 1);
        chk("t1_wdata_held", mem_wdata, 32'hABAB_ABAB);
        chk("t1_req_cycles", req_n, 3);
        chk("t1_stall_cycles", stall_n, 2);
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t1_next_req", mem_req, 1);
        chk("t1_next_addr", mem_addr, 32'h3000);
        chk("t1_next_wdata", mem_wdata, 32'h1122_3344);
        chk("t1_next_be", mem_be, 4'b1111);
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t1_idle", mem_req, 0);

        // half store with zero-wait ack, back-to-back word store
        cyc();
        req(32'h2002, 32'h1234_BEEF, 2'b01);
        cyc();
        req(32'h2004, 32'hCAFE_F00D, 2'b10);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("t2_req", mem_req, 1);
        chk("t2_addr", mem_addr, 32'h2000);
        chk("t2_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("t2_be", mem_be, 4'b1100);
        chk("t2_stall", stall, 0);
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t2_b2b_req", mem_req, 1);
        chk("t2_b2b_addr", mem_addr, 32'h2004);
        chk("t2_b2b_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("t2_b2b_be", mem_be, 4'b1111);
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t2_idle", mem_req, 0);

        // three illegal requests in a row
        cyc();
        req(32'h2001, 32'h0000_5555, 2'b01);
        cyc();
        req(32'h2006, 32'h7777_7777, 2'b10);
        @(negedge clk);
        chk("t3_mis_half", {misalign, mem_req}, 2'b10);
        cyc();
        req(32'h2000, 32'h0, 2'b11);
        @(negedge clk);
        chk("t3_mis_word", {misalign, mem_req}, 2'b10);
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t3_mis_rsvd", {misalign, mem_req}, 2'b10);
        chk("t3_addr_kept", mem_addr, 32'h2004);
        cyc();
        @(negedge clk);
        chk("t3_mis_clear", misalign, 0);

        // timeout with ack held low
        cyc();
        req(32'h4000, 32'hDEAD_BEEF, 2'b10);
        cyc();
        st_valid = 1'b0;
        req_n = 0; err_n = 0; err_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_n += int'(mem_req);
            if (bus_err) begin
                err_n++;
                err_at = i;
            end
            cyc();
        end
        chk("t4_req_cycles", req_n, 16);
        chk("t4_buserr_count", err_n, 1);
        chk("t4_buserr_at", err_at, 16);
        req(32'h4001, 32'h0000_005A, 2'b00);
        @(negedge clk);
        chk("t4_ready_after", st_ready, 1);
        cyc();
        st_valid = 1'b0;
        @(negedge clk);
        chk("t4_next_wdata", mem_wdata, 32'h5A5A_5A5A);
        chk("t4_next_be", mem_be, 4'b0010);

        // reset while BUSY
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_in_rst", st_ready, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_req", mem_req, 0);
        chk("t5_addr", mem_addr, 0);
        chk("t5_wdata", mem_wdata, 0);
        chk("t5_be", mem_be, 0);
        chk("t5_flags", {misalign, bus_err}, 0);
        chk("t5_ready", st_ready, 1);
        cyc();
        req(32'h5000, 32'h0000_ABCD, 2'b01);
        cyc();
        st_valid = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("t5_new_req", mem_req, 1);
        chk("t5_new_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("t5_new_be", mem_be, 4'b0011);
        cyc();
        mem_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_err) chk("t5_no_buserr", bus_err, 0);
            cyc();
        end

        // stray ack in IDLE
        mem_ack = 1'b1;
        @(negedge clk);
        chk("t6_req", mem_req, 0);
        chk("t6_ready", st_ready, 1);
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("t6_req_after", mem_req, 0);
        chk("t6_addr", mem_addr, 32'h5000);
        chk("t6_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("t6_be", mem_be, 4'b0011);
        chk("t6_flags", {misalign, bus_err}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
